// File: rtl/mmio_pkg.sv
// Shared MMIO bus widths, read latency and a small index-width helper
// used by the arbiter, its picker and the bench.
package mmio_pkg;

    localparam int MMIO_ADDR_W     = 30;
    localparam int MMIO_DATA_W     = 32;
    localparam int MMIO_MASK_W     = 4;
    localparam int MMIO_RD_LATENCY = 3;

    // Width of a requester index for 2..4 requesters.
    function automatic int idx_width(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/mmio_rr_picker.sv
// One-hot grant picker. Round-robin with a pointer register when
// MMIO_ARB_RR_EN is defined, fixed priority (requester 0 highest) otherwise.
module mmio_rr_picker
    import mmio_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
`ifdef MMIO_ARB_RR_EN
    input  logic               clk,
    input  logic               rst,
`endif
    input  logic [NUM_REQ-1:0] valid,
    output logic [NUM_REQ-1:0] grant
);

`ifdef MMIO_ARB_RR_EN
    localparam int PTR_W = idx_width(NUM_REQ);

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic [PTR_W:0]   cand;

    // Walk offsets from the far end back to the pointer so the first set
    // bit at or after the pointer is the last one written.
    always_comb begin
        grant = '0;
        win   = '0;
        cand  = '0;
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            cand = {1'b0, ptr} + (PTR_W + 1)'(off);
            if (cand >= (PTR_W + 1)'(NUM_REQ)) begin
                cand = cand - (PTR_W + 1)'(NUM_REQ);
            end
            if (valid[cand[PTR_W-1:0]]) begin
                grant                  = '0;
                grant[cand[PTR_W-1:0]] = 1'b1;
                win                    = cand[PTR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (|valid) begin
            ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
        end
    end
`else
    always_comb begin
        grant = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (valid[k]) begin
                grant    = '0;
                grant[k] = 1'b1;
            end
        end
    end
`endif

endmodule

// File: rtl/mmio_arbiter.sv
// Shares the MMIO port among NUM_REQ requesters and routes read data back
// through a two-stage tag pipeline. Priority scheme set by MMIO_ARB_RR_EN.
module mmio_arbiter
    import mmio_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    output logic [NUM_REQ-1:0]             o_req_ready,
    input  logic [NUM_REQ*MMIO_ADDR_W-1:0] i_req_addr,
    input  logic [NUM_REQ*MMIO_DATA_W-1:0] i_req_data,
    input  logic [NUM_REQ*MMIO_MASK_W-1:0] i_req_mask,
    input  logic [NUM_REQ-1:0]             i_req_wren,
    output logic [NUM_REQ-1:0]             o_rsp_valid,
    output logic [MMIO_DATA_W-1:0]         o_rsp_data,
    output logic [MMIO_ADDR_W-1:0]         o_mmio_addr,
    output logic [MMIO_DATA_W-1:0]         o_mmio_data,
    output logic [MMIO_MASK_W-1:0]         o_mmio_mask,
    output logic                           o_mmio_wren,
    output logic                           o_mmio_rden,
    input  logic [MMIO_DATA_W-1:0]         i_mmio_data
);

    localparam int IDX_W = idx_width(NUM_REQ);

    // Handshake: a requester holds valid and payload until it sees ready;
    // ready is one-hot, combinational, may rise in the same cycle as valid,
    // and the transfer happens on the clock edge where valid & ready.
    logic [NUM_REQ-1:0]     arb_valid;
    logic [NUM_REQ-1:0]     grant;
    logic                   accept;
    logic [MMIO_ADDR_W-1:0] sel_addr;
    logic [MMIO_DATA_W-1:0] sel_data;
    logic [MMIO_MASK_W-1:0] sel_mask;
    logic                   sel_wren;
    logic [IDX_W-1:0]       sel_idx;

    logic                   tag1_valid;
    logic [IDX_W-1:0]       tag1_idx;
    logic                   tag2_valid;
    logic [IDX_W-1:0]       tag2_idx;

    // Nothing is granted while reset is held, so ready reads 0.
    assign arb_valid = rst ? '0 : i_req_valid;

    mmio_rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) u_picker (
`ifdef MMIO_ARB_RR_EN
        .clk   (clk),
        .rst   (rst),
`endif
        .valid (arb_valid),
        .grant (grant)
    );

    assign o_req_ready = grant;
    assign accept      = |grant;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        sel_mask = '0;
        sel_wren = 1'b0;
        sel_idx  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant[k]) begin
                sel_addr = i_req_addr[k*MMIO_ADDR_W +: MMIO_ADDR_W];
                sel_data = i_req_data[k*MMIO_DATA_W +: MMIO_DATA_W];
                sel_mask = i_req_mask[k*MMIO_MASK_W +: MMIO_MASK_W];
                sel_wren = i_req_wren[k];
                sel_idx  = IDX_W'(k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_mmio_addr <= '0;
            o_mmio_data <= '0;
            o_mmio_mask <= '0;
            o_mmio_wren <= 1'b0;
            o_mmio_rden <= 1'b0;
            tag1_valid  <= 1'b0;
            tag1_idx    <= '0;
            tag2_valid  <= 1'b0;
            tag2_idx    <= '0;
            o_rsp_valid <= '0;
            o_rsp_data  <= '0;
        end else begin
            o_mmio_wren <= accept & sel_wren;
            o_mmio_rden <= accept & ~sel_wren;
            if (accept) begin
                o_mmio_addr <= sel_addr;
                o_mmio_data <= sel_data;
                o_mmio_mask <= sel_mask;
            end
            // Writes travel as invalid tags so they never raise a response.
            tag1_valid  <= accept & ~sel_wren;
            tag1_idx    <= sel_idx;
            tag2_valid  <= tag1_valid;
            tag2_idx    <= tag1_idx;
            o_rsp_valid <= '0;
            if (tag2_valid) begin
                o_rsp_valid[tag2_idx] <= 1'b1;
                o_rsp_data            <= i_mmio_data;
            end
        end
    end

endmodule
